// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU, debug and RAM port bundle for the data memory arbiter
interface dmem_arbiter_if #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int CNT_W = 16
);
    logic             cpu_req;
    logic             cpu_we;
    logic [AW-1:0]    cpu_addr;
    logic [DW-1:0]    cpu_wdata;
    logic [DW-1:0]    cpu_rdata;
    logic             cpu_stall;

    logic             dbg_req;
    logic             dbg_we;
    logic [AW-1:0]    dbg_addr;
    logic [DW-1:0]    dbg_wdata;
    logic             dbg_ack;
    logic [DW-1:0]    dbg_rdata;

    logic             mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    mem_rdata;

    logic [CNT_W-1:0] stall_cnt;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_stall, dbg_ack, dbg_rdata,
        output mem_we, mem_addr, mem_wdata, stall_cnt
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_stall, dbg_ack, dbg_rdata,
        input  mem_we, mem_addr, mem_wdata, stall_cnt
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU-priority data RAM arbiter with bounded-wait debug/loader port
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [DW-1:0]    dbg_rdata_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic             pending;
    logic             dbg_gnt;
    logic             cpu_stall;
    logic [AW-1:0]    addr_mux;
    logic [DW-1:0]    wdata_mux;

    // Everything that can reach the RAM is gated by reset so nothing is written while it is held low.
    assign pending   = bus.dbg_req & (state != ACK) & reset;
    assign dbg_gnt   = pending & (~bus.cpu_req | (cnt == CNT_MAX));
    assign cpu_stall = bus.cpu_req & dbg_gnt;
    assign addr_mux  = dbg_gnt ? bus.dbg_addr  : bus.cpu_addr;
    assign wdata_mux = dbg_gnt ? bus.dbg_wdata : bus.cpu_wdata;

    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;
    assign bus.mem_we    = reset & (dbg_gnt ? bus.dbg_we : (bus.cpu_req & bus.cpu_we));
    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.cpu_stall = cpu_stall;
    assign bus.dbg_ack   = (state == ACK);
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.stall_cnt = stall_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            dbg_rdata_q <= '0;
        end else if (dbg_gnt) begin
            state <= ACK;
            cnt   <= '0;
            if (!bus.dbg_we)
                dbg_rdata_q <= bus.mem_rdata;
        end else if (pending) begin
            state <= WAIT;
            cnt   <= cnt + 1'b1;
        end else begin
            // Covers the ACK cycle and a request dropped while waiting.
            state <= IDLE;
            cnt   <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt_q <= '0;
        else if (cpu_stall && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_q <= stall_cnt_q + 1'b1;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;
    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 5;
    localparam int SMAX     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    logic mem_init;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(32), .DW(32), .CNT_W(CNT_W)) bus ();

    dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] ram [16];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) ram[i] <= 32'h100 + i;
        end else if (bus.mem_we) begin
            ram[bus.mem_addr[3:0]] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = ram[bus.mem_addr[3:0]];

    typedef struct {
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [31:0] cpu_rdata;
        logic        cpu_stall;
        logic        dbg_ack;
        logic [31:0] dbg_rdata;
        logic [31:0] stall_cnt;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference: how many cycles the current debug request has been refused, whether the
    // previous cycle served debug, and the data the debug side last read.
    logic [31:0] ref_mem [16];
    int          denied;
    bit          served_last;
    logic [31:0] last_dbg_read;
    int          stalls;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp("mem_we",    32'(bus.mem_we),    32'(e.mem_we));
            cmp("mem_addr",  bus.mem_addr,       e.mem_addr);
            cmp("mem_wdata", bus.mem_wdata,      e.mem_wdata);
            cmp("cpu_rdata", bus.cpu_rdata,      e.cpu_rdata);
            cmp("cpu_stall", 32'(bus.cpu_stall), 32'(e.cpu_stall));
            cmp("dbg_ack",   32'(bus.dbg_ack),   32'(e.dbg_ack));
            cmp("dbg_rdata", bus.dbg_rdata,      e.dbg_rdata);
            cmp("stall_cnt", 32'(bus.stall_cnt), e.stall_cnt);
        end
    end

    task automatic cycle(input logic rst, input logic creq, input logic cwe,
                         input logic [31:0] caddr, input logic [31:0] cwd,
                         input logic dreq, input logic dwe,
                         input logic [31:0] dadr, input logic [31:0] dwd);
        exp_t e;
        bit   want, take;
        @(posedge clk);
        #1;
        reset         = rst;
        bus.cpu_req   = creq;
        bus.cpu_we    = cwe;
        bus.cpu_addr  = caddr;
        bus.cpu_wdata = cwd;
        bus.dbg_req   = dreq;
        bus.dbg_we    = dwe;
        bus.dbg_addr  = dadr;
        bus.dbg_wdata = dwd;
        if (!rst) begin
            denied = 0; served_last = 0; last_dbg_read = 0; stalls = 0;
        end
        want = rst && dreq && !served_last;
        take = want && (!creq || denied >= MAX_WAIT);
        e.mem_addr  = take ? dadr : caddr;
        e.mem_wdata = take ? dwd : cwd;
        e.mem_we    = rst && (take ? dwe : (creq && cwe));
        e.cpu_rdata = ref_mem[e.mem_addr[3:0]];
        e.cpu_stall = creq && take;
        e.dbg_ack   = served_last;
        e.dbg_rdata = last_dbg_read;
        e.stall_cnt = stalls;
        exp_q.push_back(e);
        if (rst) begin
            if (e.mem_we) ref_mem[e.mem_addr[3:0]] = e.mem_wdata;
            if (e.cpu_stall && stalls < SMAX) stalls++;
            served_last = take;
            if (take && !dwe) last_dbg_read = e.cpu_rdata;
            denied = (want && !take) ? denied + 1 : 0;
        end
    endtask

    logic        d_req, d_we;
    logic [31:0] d_addr, d_wd;

    initial begin
        reset = 1'b0; mem_init = 1'b1;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h100 + i;
        denied = 0; served_last = 0; last_dbg_read = 0; stalls = 0;
        @(posedge clk);
        #1 mem_init = 1'b0;

        // Reset held with a CPU store pending: no RAM write, registers cleared.
        for (int i = 0; i < 2; i++) begin
            cycle(0, 1, 1, 32'd5, 32'hAAAA5555, 0, 0, 0, 0);
            #1;
            cmp("t1_mem_we", 32'(bus.mem_we), 0);
            cmp("t1_dbg_ack", 32'(bus.dbg_ack), 0);
            cmp("t1_dbg_rdata", bus.dbg_rdata, 0);
            cmp("t1_stall_cnt", 32'(bus.stall_cnt), 0);
        end

        cycle(1, 1, 1, 32'd5, 32'hDEADBEEF, 0, 0, 0, 0);
        #1;
        cmp("t2_mem_we", 32'(bus.mem_we), 1);
        cmp("t2_mem_addr", bus.mem_addr, 5);
        cmp("t2_cpu_stall", 32'(bus.cpu_stall), 0);

        cycle(1, 1, 1, 32'd7, 32'h1234, 0, 0, 0, 0);
        cycle(1, 0, 0, 32'd0, 32'd0, 1, 0, 32'd7, 32'd0);
        #1 cmp("t3_mem_addr", bus.mem_addr, 7);
        cycle(1, 0, 0, 32'd0, 32'd0, 0, 0, 0, 0);
        #1;
        cmp("t3_dbg_ack", 32'(bus.dbg_ack), 1);
        cmp("t3_dbg_rdata", bus.dbg_rdata, 32'h1234);

        // CPU busy every cycle, debug write held through its first ack.
        for (int i = 0; i < 12; i++) begin
            cycle(1, 1, 0, 32'd2, 32'd0, i < 11, 1, 32'd9, 32'hCAFE0009);
            #1;
            cmp("t4_cpu_stall", 32'(bus.cpu_stall), 32'(i == 4 || i == 10));
            cmp("t4_dbg_ack", 32'(bus.dbg_ack), 32'(i == 5 || i == 11));
            if (i == 4) begin
                cmp("t4_mem_addr", bus.mem_addr, 9);
                cmp("t4_mem_we", 32'(bus.mem_we), 1);
            end
            if (i == 5) cmp("t4_stall_cnt", 32'(bus.stall_cnt), 1);
            if (i == 11) cmp("t5_stall_cnt", 32'(bus.stall_cnt), 2);
        end

        // Reset pulse while the debug request has waited two cycles.
        for (int i = 0; i < 9; i++) begin
            cycle(i != 2, 1, 1, 32'd4, 32'h44, i < 8, 0, 32'd3, 32'd0);
            #1;
            cmp("t6_cpu_stall", 32'(bus.cpu_stall), 32'(i == 7));
            cmp("t6_dbg_ack", 32'(bus.dbg_ack), 32'(i == 8));
            if (i == 2) cmp("t6_mem_we", 32'(bus.mem_we), 0);
        end

        d_req = 0; d_we = 0; d_addr = 0; d_wd = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!d_req) begin
                if ($urandom_range(2) == 0) begin
                    d_req = 1; d_we = 1'($urandom); d_addr = $urandom; d_wd = $urandom;
                end
            end else if (served_last) begin
                if ($urandom_range(3) != 0) d_req = 0;
            end else if ($urandom_range(39) == 0) begin
                d_req = 0;
            end
            cycle($urandom_range(299) != 0, $urandom_range(3) != 0, 1'($urandom),
                  $urandom, $urandom, d_req, d_we, d_addr, d_wd);
        end

        @(posedge clk);
        @(posedge clk);
        cmp("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
